// File: rtl/pico2_port_responder.sv
// I/O-port slave for the pico2 emulator: decodes the port map, fronts the key/data ROMs
// and result RAM, and holds the XTEA key/block/control/status register file.
module pico2_port_responder #(
  parameter int MEM_AW    = 8,
  parameter int KEY_BYTES = 16,
  parameter int BLK_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               port_id,
  input  logic                     write_strobe,
  input  logic                     read_strobe,
  input  logic [7:0]               out_port,
  output logic [7:0]               in_port,
  output logic [MEM_AW-1:0]        key_mem_addr,
  input  logic [7:0]               key_mem_dout,
  output logic [MEM_AW-1:0]        dat_mem_addr,
  input  logic [7:0]               dat_mem_dout,
  output logic [MEM_AW-1:0]        res_mem_addr,
  output logic [7:0]               res_mem_din,
  output logic                     res_mem_we,
  output logic [8*KEY_BYTES-1:0]   xtea_key,
  output logic [8*BLK_BYTES-1:0]   xtea_din,
  output logic                     xtea_start,
  output logic                     xtea_decrypt,
  input  logic                     xtea_done,
  input  logic [8*BLK_BYTES-1:0]   xtea_dout
);

  localparam int RPTR_W = $clog2(BLK_BYTES);

  localparam logic [7:0] P_KEY_ADDR  = 8'h20;
  localparam logic [7:0] P_KEY_DATA  = 8'h21;
  localparam logic [7:0] P_DAT_ADDR  = 8'h22;
  localparam logic [7:0] P_DAT_DATA  = 8'h23;
  localparam logic [7:0] P_KEY_SHIFT = 8'h30;
  localparam logic [7:0] P_DIN_SHIFT = 8'h31;
  localparam logic [7:0] P_CTRL      = 8'h33;
  localparam logic [7:0] P_STATUS    = 8'h34;
  localparam logic [7:0] P_RESULT    = 8'h35;
  localparam logic [7:0] P_RES_ADDR  = 8'h40;
  localparam logic [7:0] P_RES_DATA  = 8'h41;

  logic                    busy;
  logic                    done;
  logic [RPTR_W-1:0]       rptr;
  logic [8*BLK_BYTES-1:0]  res;

  logic wr_key_addr, wr_dat_addr, wr_res_addr, wr_res_data;
  logic wr_key_shift, wr_din_shift, wr_ctrl, rd_result;
  logic start_accept, done_take;
  logic [7:0] result_byte;

  function automatic logic [7:0] pick_byte(input logic [8*BLK_BYTES-1:0] blk,
                                           input logic [RPTR_W-1:0] idx);
    logic [8*BLK_BYTES-1:0] shifted;
    int unsigned sh;
    sh      = (BLK_BYTES - 1 - int'(idx)) * 8;
    shifted = blk >> sh;
    return shifted[7:0];
  endfunction

  always_comb begin
    wr_key_addr  = write_strobe && (port_id == P_KEY_ADDR);
    wr_dat_addr  = write_strobe && (port_id == P_DAT_ADDR);
    wr_res_addr  = write_strobe && (port_id == P_RES_ADDR);
    wr_res_data  = write_strobe && (port_id == P_RES_DATA);
    wr_key_shift = write_strobe && (port_id == P_KEY_SHIFT);
    wr_din_shift = write_strobe && (port_id == P_DIN_SHIFT);
    wr_ctrl      = write_strobe && (port_id == P_CTRL);
    rd_result    = read_strobe  && (port_id == P_RESULT);
    // A completion landing in the same cycle frees the core, so a start then is accepted
    start_accept = wr_ctrl && out_port[0] && (!busy || xtea_done);
    done_take    = xtea_done && busy;
  end

  always_comb begin
    result_byte = pick_byte(res, rptr);
    in_port     = 8'h00;
    case (port_id)
      P_KEY_DATA: in_port = key_mem_dout;
      P_DAT_DATA: in_port = dat_mem_dout;
      P_STATUS:   in_port = {6'b000000, busy, done};
      P_RESULT:   in_port = result_byte;
      default:    in_port = 8'h00;
    endcase
  end

  // Memory address/data registers; the result pointer advances after each RAM write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_mem_addr <= '0;
      dat_mem_addr <= '0;
      res_mem_addr <= '0;
      res_mem_din  <= '0;
      res_mem_we   <= 1'b0;
    end else begin
      res_mem_we <= wr_res_data;
      if (wr_key_addr) key_mem_addr <= out_port[MEM_AW-1:0];
      if (wr_dat_addr) dat_mem_addr <= out_port[MEM_AW-1:0];
      if (wr_res_data) res_mem_din  <= out_port;
      if (wr_res_addr)     res_mem_addr <= out_port[MEM_AW-1:0];
      else if (res_mem_we) res_mem_addr <= res_mem_addr + MEM_AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xtea_key <= '0;
      xtea_din <= '0;
    end else begin
      if (wr_key_shift) xtea_key <= {xtea_key[8*KEY_BYTES-9:0], out_port};
      if (wr_din_shift) xtea_din <= {xtea_din[8*BLK_BYTES-9:0], out_port};
    end
  end

  // Control/status: a fresh start overrides the completion flags it coincides with
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      rptr         <= '0;
      res          <= '0;
      xtea_start   <= 1'b0;
      xtea_decrypt <= 1'b0;
    end else begin
      xtea_start <= start_accept;
      if (done_take) res <= xtea_dout;
      if (start_accept) begin
        busy         <= 1'b1;
        done         <= 1'b0;
        rptr         <= '0;
        xtea_decrypt <= out_port[1];
      end else begin
        if (done_take) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        if (rd_result) rptr <= rptr + RPTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pico2_port_responder.sv
// Bench for pico2_port_responder: directed scenarios with literal expectations, then random
// port traffic compared every cycle against a transaction-level model of the register file.
module tb_pico2_port_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   port_id = 8'h00;
  logic         write_strobe = 1'b0;
  logic         read_strobe = 1'b0;
  logic [7:0]   out_port = 8'h00;
  logic [7:0]   in_port;
  logic [7:0]   key_mem_addr, dat_mem_addr, res_mem_addr, res_mem_din;
  logic [7:0]   key_mem_dout, dat_mem_dout;
  logic         res_mem_we;
  logic [127:0] xtea_key;
  logic [63:0]  xtea_din;
  logic         xtea_start, xtea_decrypt;
  logic         xtea_done = 1'b0;
  logic [63:0]  xtea_dout = 64'h0;

  pico2_port_responder dut (
    .clk(clk), .rst(rst), .port_id(port_id), .write_strobe(write_strobe),
    .read_strobe(read_strobe), .out_port(out_port), .in_port(in_port),
    .key_mem_addr(key_mem_addr), .key_mem_dout(key_mem_dout),
    .dat_mem_addr(dat_mem_addr), .dat_mem_dout(dat_mem_dout),
    .res_mem_addr(res_mem_addr), .res_mem_din(res_mem_din), .res_mem_we(res_mem_we),
    .xtea_key(xtea_key), .xtea_din(xtea_din), .xtea_start(xtea_start),
    .xtea_decrypt(xtea_decrypt), .xtea_done(xtea_done), .xtea_dout(xtea_dout)
  );

  always #5 clk = ~clk;

  logic [7:0] rom1 [256];
  logic [7:0] rom2 [256];
  logic [7:0] mem3 [256];

  always_ff @(posedge clk) begin
    key_mem_dout <= rom2[key_mem_addr];
    dat_mem_dout <= rom1[dat_mem_addr];
    if (res_mem_we) mem3[res_mem_addr] <= res_mem_din;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]   m_kaddr, m_daddr, m_raddr, m_rdin, m_kdout, m_ddout;
  logic         m_we, m_start, m_mode, m_busy, m_done;
  logic [127:0] m_key;
  logic [63:0]  m_din, m_res;
  int           m_rptr;
  logic [7:0]   mem3m [256];
  bit           m_written [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_in_port(input logic [7:0] p);
    case (p)
      8'h21:   return m_kdout;
      8'h23:   return m_ddout;
      8'h34:   return {6'b0, m_busy, m_done};
      8'h35:   return m_res[63-8*m_rptr -: 8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_all();
    chk("key_mem_addr", key_mem_addr, m_kaddr);
    chk("dat_mem_addr", dat_mem_addr, m_daddr);
    chk("res_mem_addr", res_mem_addr, m_raddr);
    chk("res_mem_din",  res_mem_din,  m_rdin);
    chk("res_mem_we",   res_mem_we,   m_we);
    chk("xtea_key",     xtea_key,     m_key);
    chk("xtea_din",     xtea_din,     m_din);
    chk("xtea_start",   xtea_start,   m_start);
    chk("xtea_decrypt", xtea_decrypt, m_mode);
    chk("in_port",      in_port,      exp_in_port(port_id));
  endtask

  task automatic model_reset();
    m_kaddr = 0; m_daddr = 0; m_raddr = 0; m_rdin = 0; m_we = 0;
    m_start = 0; m_mode = 0; m_busy = 0; m_done = 0;
    m_key = 0; m_din = 0; m_res = 0; m_rptr = 0;
  endtask

  // Effect of one clock edge given the inputs currently applied
  task automatic model_step();
    logic acc;
    m_kdout = rom2[m_kaddr];
    m_ddout = rom1[m_daddr];
    if (m_we) begin
      mem3m[m_raddr] = m_rdin;
      m_written[m_raddr] = 1'b1;
      m_raddr = m_raddr + 8'd1;
    end
    m_we = 0;
    acc = write_strobe && port_id == 8'h33 && out_port[0] && (!m_busy || xtea_done);
    m_start = acc;
    if (xtea_done && m_busy) begin
      m_res = xtea_dout; m_done = 1; m_busy = 0;
    end
    if (acc) begin
      m_busy = 1; m_done = 0; m_rptr = 0; m_mode = out_port[1];
    end else if (read_strobe && port_id == 8'h35) begin
      m_rptr = (m_rptr + 1) % 8;
    end
    if (write_strobe) begin
      case (port_id)
        8'h20: m_kaddr = out_port;
        8'h22: m_daddr = out_port;
        8'h30: m_key = {m_key[119:0], out_port};
        8'h31: m_din = {m_din[55:0], out_port};
        8'h40: m_raddr = out_port;
        8'h41: begin m_rdin = out_port; m_we = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic we, input logic rs, input logic [7:0] port,
                     input logic [7:0] data, input logic dn, input logic [63:0] dv);
    write_strobe = we; read_strobe = rs; port_id = port; out_port = data;
    xtea_done = dn; xtea_dout = dv;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    write_strobe = 0; read_strobe = 0; port_id = 8'h00; out_port = 8'h00;
    xtea_done = 0; rst = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    m_kdout = rom2[0];
    m_ddout = rom1[0];
    @(negedge clk);
    rst = 0;
    check_all();
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] ports [12];
    ports = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h33, 8'h34, 8'h35, 8'h40, 8'h41, 8'h55};
    for (int a = 0; a < 256; a++) begin
      rom2[a] = (a < 16) ? 8'(8'h10 + a) : 8'($urandom);
      rom1[a] = 8'($urandom);
      m_written[a] = 1'b0;
    end
    @(negedge clk);
    do_reset();
    chk("reset_key", xtea_key, 128'h0);
    chk("reset_start", xtea_start, 1'b0);

    // Key ROM read-through
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'h20, 8'(i), 0, 64'h0);
      cyc(0, 1, 8'h21, 8'h00, 0, 64'h0);
      cyc(0, 0, 8'h21, 8'h00, 0, 64'h0);
      chk("rom2_read", in_port, 8'(8'h10 + i));
    end

    // Key/block load and start
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h30, 8'(i), 0, 64'h0);
    for (int i = 0; i < 8; i++)  cyc(1, 0, 8'h31, 8'(8'hA0 + i), 0, 64'h0);
    chk("key_lit", xtea_key, 128'h000102030405060708090A0B0C0D0E0F);
    chk("din_lit", xtea_din, 64'hA0A1A2A3A4A5A6A7);
    cyc(1, 0, 8'h33, 8'h01, 0, 64'h0);
    chk("start_pulse", xtea_start, 1'b1);
    chk("start_mode", xtea_decrypt, 1'b0);
    cyc(0, 0, 8'h34, 8'h00, 0, 64'h0);
    chk("start_once", xtea_start, 1'b0);
    chk("status_busy", in_port, 8'h02);

    // Completion and result read-back
    cyc(0, 0, 8'h34, 8'h00, 1, 64'h1122334455667788);
    chk("status_done", in_port, 8'h01);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 8'h35, 8'h00, 0, 64'h0);
      chk("res_byte", in_port, 8'(8'h11 * (k + 1)));
      cyc(0, 1, 8'h35, 8'h00, 0, 64'h0);
    end
    cyc(0, 0, 8'h35, 8'h00, 0, 64'h0);
    chk("rptr_wrap", in_port, 8'h11);

    // Start while busy is ignored; done plus start in one cycle keeps it busy
    cyc(1, 0, 8'h33, 8'h01, 0, 64'h0);
    cyc(1, 0, 8'h33, 8'h03, 0, 64'h0);
    chk("busy_nostart", xtea_start, 1'b0);
    chk("busy_mode", xtea_decrypt, 1'b0);
    cyc(1, 0, 8'h33, 8'h03, 1, 64'hCAFEBABEDEADBEEF);
    chk("coinc_start", xtea_start, 1'b1);
    chk("coinc_mode", xtea_decrypt, 1'b1);
    cyc(0, 0, 8'h34, 8'h00, 0, 64'h0);
    chk("coinc_status", in_port, 8'h02);
    cyc(0, 0, 8'h35, 8'h00, 0, 64'h0);
    chk("coinc_res", in_port, 8'hCA);

    // Result RAM writes with address wrap
    cyc(1, 0, 8'h40, 8'hFE, 0, 64'h0);
    cyc(1, 0, 8'h41, 8'hAA, 0, 64'h0);
    cyc(1, 0, 8'h41, 8'hBB, 0, 64'h0);
    cyc(0, 0, 8'h00, 8'h00, 0, 64'h0);
    cyc(0, 0, 8'h00, 8'h00, 0, 64'h0);
    chk("mem3_fe", mem3[8'hFE], 8'hAA);
    chk("mem3_ff", mem3[8'hFF], 8'hBB);
    chk("res_addr_wrap", res_mem_addr, 8'h00);

    // Reset while busy, then a stale completion
    do_reset();
    cyc(0, 0, 8'h34, 8'h00, 1, 64'h0123456789ABCDEF);
    chk("rst_status", in_port, 8'h00);
    cyc(0, 1, 8'h55, 8'h00, 0, 64'h0);
    chk("unmapped", in_port, 8'h00);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      p = ($urandom_range(0, 12) == 12) ? 8'($urandom) : ports[$urandom_range(0, 11)];
      cyc(1'($urandom), 1'($urandom), p, 8'($urandom),
          $urandom_range(0, 5) == 0, {$urandom, $urandom});
    end
    for (int a = 0; a < 256; a++)
      if (m_written[a]) chk("mem3_rand", mem3[a], mem3m[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
